// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, state type and round/saturate helper for fir_serial_mac
package fir_pkg;

    typedef enum logic [1:0] {COLLECT, MAC, OUT} state_t;

    localparam logic [15:0] DEFAULT_COEF [16] = '{
        16'hFFF8, 16'hFFF0, 16'h0020, 16'h0060, 16'hFF40, 16'hFEC0, 16'h0280, 16'h0800,
        16'h0800, 16'h0280, 16'hFEC0, 16'hFF40, 16'h0060, 16'h0020, 16'hFFF0, 16'hFFF8
    };

    localparam int RS_W = 64;

    typedef struct packed {
        logic            sat;
        logic [RS_W-1:0] val;
    } rs_t;

    // Round half up (add 2^(shift-1), arithmetic shift), then clamp to a signed data_w range.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc, input int shift, input int data_w);
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t o;
        r     = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi    = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (data_w - 1));
        o.sat = (r > hi) || (r < lo);
        o.val = (r > hi) ? hi : (r < lo) ? lo : r;
        return o;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: full-precision signed multiply-accumulate with rounded, saturated readout
module fir_mac_unit #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 28,
    parameter int SHIFT  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [DATA_W-1:0] y_rs,
    output logic              sat_rs
);
    import fir_pkg::*;

    localparam int PW = DATA_W + COEF_W;

    logic signed [ACC_W-1:0] acc;
    logic signed [PW-1:0]    prod;
    rs_t                     rs;
    logic                    unused_rs;

    assign prod      = PW'($signed(a)) * PW'($signed(b));
    assign rs        = round_sat(RS_W'(acc), SHIFT, DATA_W);
    assign y_rs      = rs.val[DATA_W-1:0];
    assign sat_rs    = rs.sat;
    assign unused_rs = ^rs.val[RS_W-1:DATA_W];

    // Accumulator: cleared when a new sample lands, one product added per MAC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: beat-serial input, one MAC per cycle programmable FIR with rounded saturated output
module fir_serial_mac #(
    parameter int DATA_W = 8,
    parameter int HALF_W = 4,
    parameter int TAPS   = 16,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [HALF_W-1:0]       x_half,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    coef_ready,
    output logic                    y_valid,
    output logic [DATA_W-1:0]       y,
    output logic                    y_sat
);
    import fir_pkg::*;

    localparam int NBEAT = DATA_W / HALF_W;
    localparam int AW    = $clog2(TAPS);
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);

    state_t            state;
    logic [BW-1:0]     cnt;
    logic [AW-1:0]     i;
    logic [DATA_W-1:0] asm_r;
    logic [DATA_W-1:0] smp;
    logic [DATA_W-1:0] h [TAPS];
    logic [COEF_W-1:0] c [TAPS];
    logic              take;
    logic              last;
    logic [DATA_W-1:0] y_rs;
    logic              sat_rs;

    function automatic logic [COEF_W-1:0] def_coef(input int k);
        return (TAPS == 16) ? COEF_W'($signed(DEFAULT_COEF[k % 16])) : '0;
    endfunction

    assign x_ready    = state == COLLECT;
    assign coef_ready = state == COLLECT;
    assign take       = x_valid && x_ready;
    assign last       = take && cnt == BW'(NBEAT - 1);

    // The final beat goes straight into the history without a trip through the assembly register.
    always_comb begin
        smp = asm_r;
        smp[HALF_W*(NBEAT-1) +: HALF_W] = x_half;
    end

    // Beat assembly, history shift and tap sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
            cnt   <= '0;
            i     <= '0;
            asm_r <= '0;
            for (int k = 0; k < TAPS; k++) h[k] <= '0;
        end else begin
            unique case (state)
                COLLECT: if (take) begin
                    asm_r[HALF_W*cnt +: HALF_W] <= x_half;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        h[0] <= smp;
                        for (int k = 1; k < TAPS; k++) h[k] <= h[k-1];
                        i     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    i <= i + 1'b1;
                    if (i == AW'(TAPS - 1)) state <= OUT;
                end
                OUT:     state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

    // Coefficient bank: writable only while collecting, so a running MAC never sees a change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) c[k] <= def_coef(k);
        end else if (coef_we && coef_ready && 32'(coef_addr) < TAPS) begin
            c[coef_addr] <= coef_data;
        end
    end

    // Result register and its one-cycle strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y       <= '0;
            y_sat   <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= state == OUT;
            if (state == OUT) begin
                y     <= y_rs;
                y_sat <= sat_rs;
            end
        end
    end

    fir_mac_unit #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (last),
        .en    (state == MAC),
        .a     (h[i]),
        .b     (c[i]),
        .y_rs  (y_rs),
        .sat_rs(sat_rs)
    );

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed scenario checks of fir_serial_mac with hand-computed results
module tb_fir_serial_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  x_half;
    logic        x_valid;
    logic        x_ready;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        coef_ready;
    logic        y_valid;
    logic [7:0]  y;
    logic        y_sat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_serial_mac dut (
        .clk       (clk),
        .reset     (reset),
        .x_half    (x_half),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_ready(coef_ready),
        .y_valid   (y_valid),
        .y         (y),
        .y_sat     (y_sat)
    );

    task automatic do_reset;
        reset     = 1'b1;
        x_valid   = 1'b0;
        x_half    = 4'h0;
        coef_we   = 1'b0;
        coef_addr = 4'h0;
        coef_data = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic set_c0(input logic [15:0] d);
        for (int k = 0; k < 16; k++) write_coef(4'(k), (k == 0) ? d : 16'h0000);
    endtask

    task automatic send_sample(input logic [7:0] v, input logic cw, input logic [15:0] cd);
        for (int b = 0; b < 2; b++) begin
            int n;
            n = 0;
            @(negedge clk);
            x_half  = v[4*b +: 4];
            x_valid = 1'b1;
            if (b == 1 && cw) begin
                coef_we   = 1'b1;
                coef_addr = 4'h0;
                coef_data = cd;
            end
            while (!x_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!x_ready) begin
                $display("FAIL send_timeout: x_ready=%b after %0d cycles, required 1", x_ready, n);
                $fatal(1);
            end
            @(posedge clk);
            #1;
            x_valid = 1'b0;
            coef_we = 1'b0;
        end
    endtask

    task automatic wait_result(output logic [7:0] yy, output logic ss, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!y_valid && n < 200);
        if (!y_valid) begin
            $display("FAIL result_timeout: y_valid=%b after %0d cycles, required 1", y_valid, n);
            $fatal(1);
        end
        yy = y;
        ss = y_sat;
    endtask

    task automatic run(input logic [7:0] v, output logic [7:0] yy, output logic ss);
        int n;
        send_sample(v, 1'b0, 16'h0);
        wait_result(yy, ss, n);
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", y); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        checks++; if (y_sat !== 1'b0) begin errors++; $display("FAIL reset_y_sat: got %b expected 0", y_sat); end
        checks++; if (x_ready !== 1'b1) begin errors++; $display("FAIL reset_x_ready: got %b expected 1", x_ready); end
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL reset_coef_ready: got %b expected 1", coef_ready); end
    endtask

    task automatic test_passthrough;
        logic [7:0] yy;
        logic       ss;
        int         n;
        set_c0(16'h1000);
        send_sample(8'h40, 1'b0, 16'h0);
        wait_result(yy, ss, n);
        checks++; if (yy !== 8'h40) begin errors++; $display("FAIL pass_y: got %h expected 40", yy); end
        checks++; if (ss !== 1'b0) begin errors++; $display("FAIL pass_sat: got %b expected 0", ss); end
        checks++; if (n !== 18) begin errors++; $display("FAIL pass_latency: got %0d expected 18", n); end
        @(negedge clk);
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL pass_strobe_width: got %b expected 0", y_valid); end
        checks++; if (y !== 8'h40) begin errors++; $display("FAIL pass_y_hold: got %h expected 40", y); end
    endtask

    task automatic test_saturation;
        logic [7:0] yy;
        logic       ss;
        set_c0(16'h2000);
        run(8'h50, yy, ss);
        checks++; if (yy !== 8'h7F) begin errors++; $display("FAIL sat_pos_y: got %h expected 7f", yy); end
        checks++; if (ss !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b expected 1", ss); end
        run(8'hB0, yy, ss);
        checks++; if (yy !== 8'h80) begin errors++; $display("FAIL sat_neg_y: got %h expected 80", yy); end
        checks++; if (ss !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b expected 1", ss); end
    endtask

    task automatic test_rounding;
        logic [7:0] yy;
        logic       ss;
        set_c0(16'h0800);
        run(8'h03, yy, ss);
        checks++; if (yy !== 8'h02) begin errors++; $display("FAIL round_pos: got %h expected 02", yy); end
        checks++; if (ss !== 1'b0) begin errors++; $display("FAIL round_pos_sat: got %b expected 0", ss); end
        run(8'hFD, yy, ss);
        checks++; if (yy !== 8'hFF) begin errors++; $display("FAIL round_neg: got %h expected ff", yy); end
        checks++; if (ss !== 1'b0) begin errors++; $display("FAIL round_neg_sat: got %b expected 0", ss); end
    endtask

    task automatic test_coef_on_last_beat;
        logic [7:0] yy;
        logic       ss;
        int         n;
        set_c0(16'h1000);
        send_sample(8'h30, 1'b1, 16'h2000);
        wait_result(yy, ss, n);
        checks++; if (yy !== 8'h60) begin errors++; $display("FAIL coef_last_beat: got %h expected 60", yy); end
        run(8'h30, yy, ss);
        checks++; if (yy !== 8'h60) begin errors++; $display("FAIL coef_persist: got %h expected 60", yy); end
    endtask

    task automatic test_handshake;
        logic [7:0] yy;
        logic       ss;
        int         n;
        set_c0(16'h1000);
        send_sample(8'h25, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL mac_x_ready: got %b expected 0", x_ready); end
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL mac_coef_ready: got %b expected 0", coef_ready); end
        x_valid   = 1'b1;
        x_half    = 4'hF;
        coef_we   = 1'b1;
        coef_addr = 4'h0;
        coef_data = 16'h7FFF;
        repeat (3) @(negedge clk);
        x_valid = 1'b0;
        coef_we = 1'b0;
        wait_result(yy, ss, n);
        checks++; if (yy !== 8'h25) begin errors++; $display("FAIL mac_ignore_y: got %h expected 25", yy); end
        run(8'h13, yy, ss);
        checks++; if (yy !== 8'h13) begin errors++; $display("FAIL mac_ignore_next: got %h expected 13", yy); end
        @(negedge clk);
        x_half  = 4'h7;
        x_valid = 1'b1;
        @(posedge clk);
        #1 x_valid = 1'b0;
        repeat (5) @(negedge clk);
        x_half  = 4'h3;
        x_valid = 1'b1;
        @(posedge clk);
        #1 x_valid = 1'b0;
        wait_result(yy, ss, n);
        checks++; if (yy !== 8'h37) begin errors++; $display("FAIL gap_between_beats: got %h expected 37", yy); end
    endtask

    task automatic test_default_impulse;
        logic [7:0] exp_y [9] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'hFD, 8'hFB, 8'h0A, 8'h20, 8'h20};
        logic [7:0] yy;
        logic       ss;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            run((k == 0) ? 8'h40 : 8'h00, yy, ss);
            checks++;
            if (yy !== exp_y[k]) begin errors++; $display("FAIL impulse_%0d: got %h expected %h", k, yy, exp_y[k]); end
        end
    endtask

    task automatic test_default_dc;
        logic [7:0] yy;
        logic       ss;
        do_reset();
        for (int k = 0; k < 16; k++) run(8'h10, yy, ss);
        checks++; if (yy !== 8'h12) begin errors++; $display("FAIL dc_y: got %h expected 12", yy); end
        checks++; if (ss !== 1'b0) begin errors++; $display("FAIL dc_sat: got %b expected 0", ss); end
    endtask

    task automatic test_reset_mid_mac;
        logic [7:0] exp_y [8] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'hFD, 8'hFB, 8'h0A, 8'h20};
        logic [7:0] yy;
        logic       ss;
        int         seen;
        set_c0(16'h1000);
        run(8'h40, yy, ss);
        send_sample(8'h40, 1'b0, 16'h0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL midmac_y: got %h expected 00", y); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL midmac_y_valid: got %b expected 0", y_valid); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (y_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midmac_no_strobe: got %0d strobes expected 0", seen); end
        for (int k = 0; k < 8; k++) begin
            run((k == 0) ? 8'h40 : 8'h00, yy, ss);
            checks++;
            if (yy !== exp_y[k]) begin errors++; $display("FAIL post_reset_impulse_%0d: got %h expected %h", k, yy, exp_y[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_saturation();
        test_rounding();
        test_coef_on_last_beat();
        test_handshake();
        test_default_impulse();
        test_default_dc();
        test_reset_mid_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
